// File: rtl/wii_cam_controller.sv
// Wii IR camera sequencer: runs the init write ROM once through i2c_master,
// then polls the camera and decodes blob 1 (extended mode 3).
module wii_cam_controller #(
    parameter logic [6:0]  CAM_ADDR    = 7'h58,
    parameter int unsigned STEP_DELAY  = 120000,
    parameter int unsigned POLL_PERIOD = 60000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i2c_ready,
    input  logic [127:0] i2c_rdata,
    output logic         i2c_start,
    output logic         i2c_rw,
    output logic [6:0]   i2c_addr,
    output logic [4:0]   i2c_packets,
    output logic [127:0] i2c_data,
    output logic [9:0]   blob_x,
    output logic [9:0]   blob_y,
    output logic [3:0]   blob_size,
    output logic         blob_present,
    output logic         blob_valid,
    output logic         init_done
);

    typedef enum logic [3:0] {
        IDLE, INIT_LOAD, INIT_START, INIT_BUSY, INIT_DONE, INIT_DELAY,
        REQ_LOAD, REQ_START, REQ_BUSY, REQ_DONE,
        RD_LOAD, RD_START, RD_BUSY, RD_DONE,
        DECODE, POLL_WAIT
    } state_e;

    typedef struct packed {
        logic [4:0]   pkts;
        logic [127:0] data;
    } rom_t;

    state_e       state_q;
    logic [2:0]   step_q;
    logic [31:0]  cnt_q;
    logic         start_q, rw_q, valid_q, init_done_q, present_q;
    logic [4:0]   pkts_q;
    logic [127:0] data_q;
    logic [9:0]   bx_q, by_q;
    logic [3:0]   bsize_q;

    logic [9:0]   bx_d, by_d;
    logic [3:0]   bsize_d;
    logic         present_d;
    rom_t         rom;
    logic         unused_rdata;

    function automatic rom_t init_rom(input logic [2:0] step);
        rom_t r;
        r = '0;
        case (step)
            3'd0:    begin r.pkts = 5'd2; r.data[15:0] = 16'h0130;              end
            3'd1:    begin r.pkts = 5'd8; r.data[63:0] = 64'hAA00017100000200;  end
            3'd2:    begin r.pkts = 5'd3; r.data[23:0] = 24'h640007;            end
            3'd3:    begin r.pkts = 5'd3; r.data[23:0] = 24'h03631A;            end
            3'd4:    begin r.pkts = 5'd2; r.data[15:0] = 16'h0333;              end
            default: begin r.pkts = 5'd2; r.data[15:0] = 16'h0830;              end
        endcase
        return r;
    endfunction

    // A zero-length delay still occupies one cycle in its wait state.
    function automatic logic delay_done(input logic [31:0] cnt, input int unsigned n);
        return (n == 0) || ((cnt + 32'd1) >= n);
    endfunction

    assign rom          = init_rom(step_q);
    assign bx_d         = {i2c_rdata[29:28], i2c_rdata[15:8]};
    assign by_d         = {i2c_rdata[31:30], i2c_rdata[23:16]};
    assign bsize_d      = i2c_rdata[27:24];
    assign present_d    = !(bx_d == 10'h3FF && by_d == 10'h3FF);
    assign unused_rdata = ^{i2c_rdata[127:32], i2c_rdata[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            rw_q        <= 1'b0;
            pkts_q      <= '0;
            data_q      <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            bsize_q     <= '0;
            present_q   <= 1'b0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE:       if (i2c_ready) state_q <= INIT_LOAD;
                INIT_LOAD: begin
                    rw_q    <= 1'b0;
                    pkts_q  <= rom.pkts;
                    data_q  <= rom.data;
                    state_q <= INIT_START;
                end
                INIT_START: if (i2c_ready) begin start_q <= 1'b1; state_q <= INIT_BUSY; end
                INIT_BUSY:  if (!i2c_ready) state_q <= INIT_DONE;
                INIT_DONE:  if (i2c_ready)  state_q <= INIT_DELAY;
                INIT_DELAY: begin
                    if (delay_done(cnt_q, STEP_DELAY)) begin
                        cnt_q <= '0;
                        if (step_q != 3'd5) begin
                            step_q  <= step_q + 3'd1;
                            state_q <= INIT_LOAD;
                        end else begin
                            init_done_q <= 1'b1;
                            state_q     <= REQ_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                REQ_LOAD: begin
                    rw_q    <= 1'b0;
                    pkts_q  <= 5'd1;
                    data_q  <= {120'd0, 8'h36};
                    state_q <= REQ_START;
                end
                REQ_START:  if (i2c_ready) begin start_q <= 1'b1; state_q <= REQ_BUSY; end
                REQ_BUSY:   if (!i2c_ready) state_q <= REQ_DONE;
                REQ_DONE:   if (i2c_ready)  state_q <= RD_LOAD;
                RD_LOAD: begin
                    rw_q    <= 1'b1;
                    pkts_q  <= 5'd16;
                    data_q  <= '0;
                    state_q <= RD_START;
                end
                RD_START:   if (i2c_ready) begin start_q <= 1'b1; state_q <= RD_BUSY; end
                RD_BUSY:    if (!i2c_ready) state_q <= RD_DONE;
                RD_DONE:    if (i2c_ready)  state_q <= DECODE;
                DECODE: begin
                    bx_q      <= bx_d;
                    by_q      <= by_d;
                    bsize_q   <= bsize_d;
                    present_q <= present_d;
                    valid_q   <= 1'b1;
                    state_q   <= POLL_WAIT;
                end
                POLL_WAIT: begin
                    if (delay_done(cnt_q, POLL_PERIOD)) begin
                        cnt_q   <= '0;
                        state_q <= REQ_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default:    state_q <= IDLE;
            endcase
        end
    end

    assign i2c_start    = start_q;
    assign i2c_rw       = rw_q;
    assign i2c_addr     = CAM_ADDR;
    assign i2c_packets  = pkts_q;
    assign i2c_data     = data_q;
    assign blob_x       = bx_q;
    assign blob_y       = by_q;
    assign blob_size    = bsize_q;
    assign blob_present = present_q;
    assign blob_valid   = valid_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_wii_cam_controller.sv
// Bench for wii_cam_controller: mock i2c_master plus a transaction/blob reference model.
module tb_wii_cam_controller;
    localparam int STEP_DELAY  = 4;
    localparam int POLL_PERIOD = 8;
    localparam logic [7:0] INIT_ROM [6][8] = '{
        '{8'h30, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h02, 8'h00, 8'h00, 8'h71, 8'h01, 8'h00, 8'hAA},
        '{8'h07, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h1A, 8'h63, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h33, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h30, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    localparam int INIT_LEN [6] = '{2, 8, 3, 3, 2, 2};

    logic         clk = 1'b0, reset = 1'b0, i2c_ready = 1'b0;
    logic [127:0] i2c_rdata = '0;
    logic         i2c_start, i2c_rw, blob_present, blob_valid, init_done;
    logic [6:0]   i2c_addr;
    logic [4:0]   i2c_packets;
    logic [127:0] i2c_data;
    logic [9:0]   blob_x, blob_y;
    logic [3:0]   blob_size;

    wii_cam_controller #(.CAM_ADDR(7'h58), .STEP_DELAY(STEP_DELAY), .POLL_PERIOD(POLL_PERIOD)) dut (
        .clk(clk), .reset(reset), .i2c_ready(i2c_ready), .i2c_rdata(i2c_rdata),
        .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_packets(i2c_packets),
        .i2c_data(i2c_data), .blob_x(blob_x), .blob_y(blob_y), .blob_size(blob_size),
        .blob_present(blob_present), .blob_valid(blob_valid), .init_done(init_done));

    always #5 clk = ~clk;

    typedef struct {
        logic         rw;
        logic [4:0]   pkts;
        logic [127:0] data;
        logic [6:0]   addr;
    } txn_t;

    txn_t       log_q[$];
    int         checks = 0, errors = 0;
    int         mode = 2;  // 0: mock master, 1: ready stuck high, 2: ready stuck low
    int         busy_cnt = 0, start_cnt = 0, start_run = 0, valid_cnt = 0;
    logic [7:0] rb [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Mock i2c_master: ready drops on the start pulse and stays low 5 cycles.
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt  = 0;
            start_run = 0;
            i2c_ready = (mode != 2);
        end else begin
            if (blob_valid) valid_cnt++;
            if (i2c_start) begin
                start_cnt++;
                start_run++;
                chk("start_len", 128'(start_run), 128'd1);
                chk("start_ready", {127'd0, i2c_ready}, 128'd1);
                log_q.push_back('{rw: i2c_rw, pkts: i2c_packets, data: i2c_data, addr: i2c_addr});
            end else begin
                start_run = 0;
            end
            if (mode == 0) begin
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        chk("hold_pkts", 128'(i2c_packets), 128'(log_q[$].pkts));
                        chk("hold_rw", {127'd0, i2c_rw}, {127'd0, log_q[$].rw});
                        chk("hold_data", i2c_data, log_q[$].data);
                        i2c_ready = 1'b1;
                    end
                end else if (i2c_start) begin
                    busy_cnt  = 5;
                    i2c_ready = 1'b0;
                    if (i2c_rw)
                        i2c_rdata = {$urandom, $urandom, $urandom, rb[3], rb[2], rb[1], rb[0]};
                end else begin
                    i2c_ready = 1'b1;
                end
            end else begin
                i2c_ready = (mode == 1);
            end
        end
    end

    function automatic txn_t exp_txn(input int idx);
        txn_t t;
        t.addr = 7'h58;
        t.data = '0;
        if (idx < 6) begin
            t.rw   = 1'b0;
            t.pkts = 5'(INIT_LEN[idx]);
            for (int i = 0; i < INIT_LEN[idx]; i++) t.data[i*8 +: 8] = INIT_ROM[idx][i];
        end else if ((idx - 6) % 2 == 0) begin
            t.rw   = 1'b0;
            t.pkts = 5'd1;
            t.data[7:0] = 8'h36;
        end else begin
            t.rw   = 1'b1;
            t.pkts = 5'd16;
        end
        return t;
    endfunction

    task automatic check_txn(input int k, input int e);
        txn_t a, x;
        logic [127:0] m;
        a = log_q[k];
        x = exp_txn(e);
        m = '0;
        chk($sformatf("txn%0d_rw", k), {127'd0, a.rw}, {127'd0, x.rw});
        chk($sformatf("txn%0d_pkts", k), 128'(a.pkts), 128'(x.pkts));
        chk($sformatf("txn%0d_addr", k), 128'(a.addr), 128'(x.addr));
        if (!x.rw) begin
            for (int i = 0; i < int'(x.pkts); i++) m[i*8 +: 8] = 8'hFF;
            chk($sformatf("txn%0d_data", k), a.data & m, x.data);
        end
    endtask

    task automatic wait_txns(input int n, input int budget, input string tag);
        int k = 0;
        while (log_q.size() < n && k < budget) begin tick(); k++; end
        chk(tag, {127'd0, log_q.size() >= n}, 128'd1);
    endtask

    task automatic wait_valid(input int n, input string tag);
        int k = 0;
        while (valid_cnt < n && k < 400) begin tick(); k++; end
        chk(tag, {127'd0, valid_cnt >= n}, 128'd1);
    endtask

    task automatic chk_blob(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        int x, y;
        x = ((int'(b3) >> 4) & 3) * 256 + int'(b1);
        y = ((int'(b3) >> 6) & 3) * 256 + int'(b2);
        chk("blob_x", 128'(blob_x), 128'(x));
        chk("blob_y", 128'(blob_y), 128'(y));
        chk("blob_size", 128'(blob_size), 128'(int'(b3) % 16));
        chk("blob_present", {127'd0, blob_present}, {127'd0, !(x == 1023 && y == 1023)});
        chk("blob_valid", {127'd0, blob_valid}, 128'd1);
    endtask

    initial begin
        int gap, sc, base, kx;
        logic [7:0] b1, b2, b3;
        rb = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) tick();
        chk("rst_start", {127'd0, i2c_start}, 128'd0);
        chk("rst_rw", {127'd0, i2c_rw}, 128'd0);
        chk("rst_addr", 128'(i2c_addr), 128'h58);
        chk("rst_pkts", 128'(i2c_packets), 128'd0);
        chk("rst_data", i2c_data, 128'd0);
        chk("rst_blob", {94'd0, blob_x, blob_y, blob_size, blob_present, blob_valid}, 128'd0);
        chk("rst_init_done", {127'd0, init_done}, 128'd0);

        reset = 1'b1;
        repeat (20) tick();
        chk("no_start_ready_low", 128'(start_cnt), 128'd0);
        mode = 0;

        wait_txns(6, 600, "init_txns");
        for (int k = 0; k < 6; k++) check_txn(k, k);
        chk("write2_data", {64'd0, log_q[1].data[63:0]}, {64'd0, 64'hAA00017100000200});
        chk("init_done_low", {127'd0, init_done}, 128'd0);
        begin
            int k = 0;
            while (!init_done && k < 200) begin tick(); k++; end
        end
        chk("init_done_high", {127'd0, init_done}, 128'd1);
        chk("init_done_txns", 128'(log_q.size()), 128'd6);

        // First poll with fixed blob bytes, then timing of the poll period.
        rb = '{8'h5C, 8'h34, 8'h12, 8'hA7};
        wait_valid(1, "valid1");
        check_txn(6, 6);
        check_txn(7, 7);
        chk_blob(8'h34, 8'h12, 8'hA7);
        chk("blob_x_lit", 128'(blob_x), 128'h234);
        rb = '{8'(($urandom)), 8'h00, 8'h00, 8'h00};
        sc = start_cnt;
        gap = 0;
        while (start_cnt == sc && gap < 100) begin
            tick();
            gap++;
            if (gap == 1) chk("valid_pulse", {127'd0, blob_valid}, 128'd0);
        end
        chk("poll_gap", 128'(gap), 128'(POLL_PERIOD + 2));
        chk("blob_hold", 128'(blob_x), 128'h234);
        kx = 8;

        for (int it = 0; it < 5; it++) begin
            if (it == 4) begin b1 = 8'hFF; b2 = 8'hFF; b3 = 8'hFF; end
            else begin b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom); end
            rb = '{8'($urandom), b1, b2, b3};
            wait_valid(2 + it, $sformatf("valid_it%0d", it));
            check_txn(kx, kx);
            check_txn(kx + 1, kx + 1);
            kx += 2;
            chk_blob(b1, b2, b3);
        end
        chk("blob_absent", {127'd0, blob_present}, 128'd0);

        // Ready stuck high: exactly one request start, then the controller waits.
        mode = 1;
        sc = start_cnt;
        repeat (60) tick();
        chk("stuck_ready_starts", 128'(start_cnt), 128'(sc + 1));
        chk("stuck_ready_valid", 128'(valid_cnt), 128'd6);
        check_txn(log_q.size() - 1, 6);

        // Reset asserted in the middle of the 4th init write.
        reset = 1'b0;
        tick();
        mode = 0;
        reset = 1'b1;
        base = log_q.size();
        wait_txns(base + 4, 600, "reinit_txns");
        tick();
        chk("mid_write_pkts", 128'(i2c_packets), 128'd3);
        #2 reset = 1'b0;
        #1;
        chk("arst_start", {127'd0, i2c_start}, 128'd0);
        chk("arst_pkts", 128'(i2c_packets), 128'd0);
        chk("arst_data", i2c_data, 128'd0);
        chk("arst_init_done", {127'd0, init_done}, 128'd0);
        chk("arst_blob", {94'd0, blob_x, blob_y, blob_size, blob_present, blob_valid}, 128'd0);
        tick();
        reset = 1'b1;
        base = log_q.size();
        wait_txns(base + 1, 100, "restart_txn");
        check_txn(base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wii_cam_controller.md
Name: wii_cam_controller

Overview:
- Sequencer that sits directly upstream of i2c_master and drives its addr/data/packets/rw/start inputs.
- After reset it runs the Wii IR camera initialisation write sequence once.
- It then periodically polls the camera and decodes blob 1 (extended mode 3) into x/y/size for the tracking logic.
- It owns no I2C pins; all bus activity goes through i2c_master.

Parameters:
- CAM_ADDR, 7'h58, 7-bit I2C address of the camera.
- STEP_DELAY, 120000, idle clk cycles between consecutive init writes and after the last one.
- POLL_PERIOD, 60000, idle clk cycles between the end of one poll read and the next poll request.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i2c_ready  input  1  master idle/done flag.
- i2c_rdata  input  128  master read data; byte i at [i*8+:8], byte 0 received first.
- i2c_start  output  1  one-cycle start pulse to master.
- i2c_rw  output  1  0 = write, 1 = read.
- i2c_addr  output  7  always CAM_ADDR.
- i2c_packets  output  5  byte count of the transaction.
- i2c_data  output  128  write payload; byte i at [i*8+:8], byte 0 sent first.
- blob_x  output  10  blob 1 x coordinate.
- blob_y  output  10  blob 1 y coordinate.
- blob_size  output  4  blob 1 size.
- blob_present  output  1  1 when the last decoded blob is not 1023/1023.
- blob_valid  output  1  one-cycle pulse when blob_* update.
- init_done  output  1  high once the init sequence has completed.

Behaviour:
- Reset (reset=0, async): state IDLE. i2c_start=0, i2c_rw=0, i2c_packets=0, i2c_data=0, blob_*=0, blob_valid=0, init_done=0, all counters 0. i2c_addr is the constant CAM_ADDR.
- Init ROM, 6 writes, in order (bytes listed byte 0 first):
  - {30 01}
  - {00 02 00 00 71 01 00 AA}
  - {07 00 64}
  - {1A 63 03}
  - {33 03}
  - {30 08}
- Transaction handshake:
  - Load i2c_data, i2c_packets and i2c_rw in the cycle before start, and hold them stable until the transaction completes.
  - Assert i2c_start for exactly 1 cycle, and only while i2c_ready=1.
  - Wait for i2c_ready=0 (BUSY), then for i2c_ready=1 (DONE). That rise marks completion.
  - Never issue start while i2c_ready=0.
- States:
  - IDLE: wait i2c_ready=1 -> INIT_LOAD.
  - INIT_LOAD: load ROM[step] -> INIT_START.
  - INIT_START: pulse start -> INIT_BUSY.
  - INIT_BUSY: wait ready=0 -> INIT_DONE.
  - INIT_DONE: wait ready=1 -> INIT_DELAY.
  - INIT_DELAY: count STEP_DELAY cycles. If step<5: step+1, -> INIT_LOAD. Else set init_done=1 (held until reset), -> REQ_LOAD.
  - REQ_LOAD: data byte0=8'h36, packets=1, rw=0 -> REQ_START -> REQ_BUSY -> REQ_DONE.
  - REQ_DONE: -> RD_LOAD.
  - RD_LOAD: packets=16, rw=1 -> RD_START -> RD_BUSY -> RD_DONE.
  - RD_DONE: -> DECODE.
  - DECODE: uses bytes b1..b3 of i2c_rdata.
    - blob_x = {b3[5:4], b1}.
    - blob_y = {b3[7:6], b2}.
    - blob_size = b3[3:0].
    - blob_present = !(blob_x==1023 && blob_y==1023).
    - blob_valid=1 for this cycle only. -> POLL_WAIT.
  - POLL_WAIT: count POLL_PERIOD cycles -> REQ_LOAD.
- Latency:
  - DECODE is the cycle after the i2c_ready rise that ends the read.
  - blob_* are registered, so they are visible the next cycle, coincident with blob_valid.
- Boundary conditions:
  - A delay count of 0 means a 1-cycle pass-through.
  - blob_* hold their values between blob_valid pulses.
  - A start pulse never lasts longer than 1 cycle, even if ready stays 1.
  - Reset mid-transaction aborts immediately and restarts init from step 0. init_done clears.
  - Byte 0 of the read payload is ignored.

Test Plan:
- Release reset with ready=1 and a mock master (ready low 5 cycles after start), STEP_DELAY=4, POLL_PERIOD=8 -> six writes with packets 2,8,3,3,2,2. The second write's i2c_data[63:0]=64'hAA00017100000200. init_done rises after the 6th delay.
- After init -> write packets=1, data[7:0]=8'h36, rw=0. Then read packets=16, rw=1. Then POLL_WAIT of 8 cycles and the request repeats.
- Mock read with b1=8'h34, b2=8'h12, b3=8'hA7 -> blob_x=10'h234, blob_y=10'h212, blob_size=7, blob_present=1, one blob_valid pulse.
- Mock read with b1=b2=b3=8'hFF -> blob_x=blob_y=1023, blob_size=15, blob_present=0.
- Hold ready=1 permanently after start (master never busy) -> controller stays in *_BUSY and issues no further start. Hold ready=0 at reset -> no start until ready=1.
- Assert reset during the 4th init write -> all outputs return to reset values asynchronously. After release, the sequence restarts with packets=2 and data {30 01}.
